// File: rtl/my_rr_arbiter4way16.sv
// Four-way round-robin burst arbiter sharing one 16-bit bus.
// A requester wins the bus, transfers beats while it keeps req high, and gives
// the bus up on its last beat, on the MAX_BEATS-th beat, or when it drops req.
// One IDLE bubble cycle always separates consecutive grants.

// 4:1 word multiplexer used to route the owner's data onto the bus.
module my_mux4way16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic [1:0]  sel,
   output logic [15:0] out
);

   // Pure select; every sel value is covered so no storage is implied.
   always_comb begin
      unique case (sel)
         2'd0:    out = a;
         2'd1:    out = b;
         2'd2:    out = c;
         default: out = d;
      endcase
   end

endmodule

module my_rr_arbiter4way16 #(
   parameter int MAX_BEATS = 8,
   parameter int CNT_W     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [3:0]  last,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic        out_ready,
   output logic [15:0] out,
   output logic        out_valid,
   output logic [3:0]  grant,
   output logic [3:0]  beat_ack
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state, state_nx;
   logic [1:0]       ptr, ptr_nx;
   logic [1:0]       sel, sel_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   logic [1:0]       winner;
   logic [1:0]       scan_idx;
   logic             found;
   logic             beat;
   logic             release_now;
   logic             owner_req;
   logic             at_limit;
   logic [15:0]      mux_out;

   my_mux4way16 u_mux (
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .sel (sel),
      .out (mux_out)
   );

   // State register: owner, priority pointer and beat count of the current burst.
   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignment so every register samples
      // the values from before this edge, independent of statement order.
      if (reset) begin
         state <= IDLE;
         ptr   <= 2'd0;
         sel   <= 2'd0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
         sel   <= sel_nx;
         cnt   <= cnt_nx;
      end
   end

   // Round-robin scan: first requester at or after ptr, wrapping modulo 4.
   always_comb begin
      // NOTE: every variable driven here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      winner   = ptr;
      found    = 1'b0;
      scan_idx = ptr;
      for (int k = 0; k < 4; k++) begin
         scan_idx = ptr + k[1:0];
         if (!found && req[scan_idx]) begin
            winner = scan_idx;
            found  = 1'b1;
         end
      end
   end

   // Burst bookkeeping shared by next-state and output logic. Reset masks the
   // bus combinationally so a burst aborted by reset never shows a final ack.
   always_comb begin
      owner_req   = req[sel];
      at_limit    = (cnt == CNT_W'(MAX_BEATS - 1));
      beat        = (state == BUSY) && owner_req && out_ready && !reset;
      release_now = (state == BUSY) &&
                    (!owner_req || (beat && (last[sel] || at_limit)));
   end

   // Next-state logic: grant from IDLE, count beats and release from BUSY.
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      sel_nx   = sel;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (req != 4'b0000) begin
               sel_nx   = winner;
               cnt_nx   = '0;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            if (release_now) begin
               state_nx = IDLE;
               ptr_nx   = sel + 2'd1;
               cnt_nx   = '0;
            end else if (beat) begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Output logic: grant follows the owner, data is zero unless a beat is offered.
   always_comb begin
      grant     = 4'b0000;
      out_valid = 1'b0;
      out       = 16'h0000;
      beat_ack  = 4'b0000;
      if (state == BUSY && !reset) begin
         grant     = 4'b0001 << sel;
         out_valid = owner_req;
         if (owner_req) out = mux_out;
         if (beat) beat_ack = 4'b0001 << sel;
      end
   end

endmodule

// File: tb/tb_my_rr_arbiter4way16.sv
// Self-checking bench for my_rr_arbiter4way16: directed scenarios followed by
// randomized traffic, all outputs compared every cycle against a burst-level model.
module tb_my_rr_arbiter4way16;

   localparam int MAX_BEATS = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req, last;
   logic [15:0] a, b, c, d;
   logic        out_ready;
   logic [15:0] out;
   logic        out_valid;
   logic [3:0]  grant, beat_ack;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: who owns the bus (-1 = nobody), where the next scan
   // starts, and how many beats the owner has delivered in this grant.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_beats = 0;

   always #5 clk = ~clk;

   my_rr_arbiter4way16 #(.MAX_BEATS(MAX_BEATS), .CNT_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .last      (last),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .out_ready (out_ready),
      .out       (out),
      .out_valid (out_valid),
      .grant     (grant),
      .beat_ack  (beat_ack)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] word_of(input int i);
      case (i)
         0:       return a;
         1:       return b;
         2:       return c;
         default: return d;
      endcase
   endfunction

   // Mid-cycle: compare every output with what the model predicts.
   task automatic sample();
      logic [3:0]  eg, ea;
      logic        ev;
      logic [15:0] eo;
      @(negedge clk);
      eg = 4'b0000; ea = 4'b0000; ev = 1'b0; eo = 16'h0000;
      if (!reset && m_owner >= 0) begin
         eg = 4'(1 << m_owner);
         ev = req[m_owner];
         if (ev) eo = word_of(m_owner);
         if (ev && out_ready) ea = eg;
      end
      check("grant", grant, eg);
      check("out_valid", out_valid, ev);
      check("out", out, eo);
      check("beat_ack", beat_ack, ea);
   endtask

   // Clock edge: move the model one cycle forward using the current inputs.
   task automatic advance();
      bit beat;
      bit found;
      int idx;
      @(posedge clk);
      if (reset) begin
         m_owner = -1;
         m_ptr   = 0;
         m_beats = 0;
      end else if (m_owner < 0) begin
         found = 0;
         for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (!found && req[idx]) begin
               m_owner = idx;
               m_beats = 0;
               found   = 1;
            end
         end
      end else begin
         beat = req[m_owner] && out_ready;
         if (beat) m_beats++;
         if (!req[m_owner] || (beat && (last[m_owner] || m_beats == MAX_BEATS))) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_beats = 0;
         end
      end
      #1;
   endtask

   task automatic cycle();
      sample();
      advance();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   logic [3:0]  rr_grant [9];
   logic [15:0] rr_word  [4];
   int          acks;

   initial begin
      rr_grant = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001};
      rr_word  = '{16'h5555, 16'hAAAA, 16'h00FF, 16'hFF00};

      // Reset held with everyone requesting: bus stays quiet.
      reset = 1'b1; req = 4'b1111; last = 4'b0000; out_ready = 1'b1;
      a = 16'h5555; b = 16'hAAAA; c = 16'h00FF; d = 16'hFF00;
      repeat (2) begin
         sample();
         check("rst_grant", grant, 4'b0000);
         check("rst_out", out, 16'h0000);
         advance();
      end
      reset = 1'b0;

      // Single requester, one-beat burst.
      req = 4'b0010; last = 4'b0010;
      cycle();
      sample();
      check("single_grant", grant, 4'b0010);
      check("single_out", out, 16'hAAAA);
      check("single_ack", beat_ack, 4'b0010);
      advance();
      req = 4'b0000;
      sample();
      check("single_release", grant, 4'b0000);
      advance();
      // Pointer now 2: requester 2 beats requester 0.
      req = 4'b0101; last = 4'b0100;
      cycle();
      sample();
      check("single_ptr2", grant, 4'b0100);
      advance();
      req = 4'b0000;
      cycle();

      // Round robin across all four with one-beat bursts.
      do_reset();
      req = 4'b1111; last = 4'b1111;
      cycle();
      for (int i = 0; i < 9; i++) begin
         sample();
         check("rr_grant", grant, rr_grant[i]);
         if (i % 2 == 0) check("rr_out", out, rr_word[(i / 2) % 4]);
         advance();
      end

      // Forced release after MAX_BEATS beats, then re-grant to sole requester.
      do_reset();
      req = 4'b0001; last = 4'b0000; acks = 0;
      for (int i = 0; i < 11; i++) begin
         sample();
         if (i < 10 && beat_ack[0]) acks++;
         if (i == 9)  check("limit_bubble", grant, 4'b0000);
         if (i == 10) check("limit_regrant", grant, 4'b0001);
         advance();
      end
      check("limit_acks", acks, MAX_BEATS);

      // Backpressure: word held, no ack, then one ack with last.
      do_reset();
      req = 4'b0100; last = 4'b0000; out_ready = 1'b0;
      cycle();
      repeat (5) begin
         sample();
         check("bp_out", out, 16'h00FF);
         check("bp_ack", beat_ack, 4'b0000);
         advance();
      end
      out_ready = 1'b1; last = 4'b0100;
      sample();
      check("bp_ack_last", beat_ack, 4'b0100);
      advance();
      sample();
      check("bp_release", grant, 4'b0000);
      advance();

      // Abandon: owner drops req, pointer moves past it.
      do_reset();
      req = 4'b0010; last = 4'b0000;
      repeat (3) cycle();
      req = 4'b0101;
      cycle();
      sample();
      check("abandon_idle", grant, 4'b0000);
      advance();
      sample();
      check("abandon_next", grant, 4'b0100);
      advance();
      // Reset in the middle of requester 2's burst.
      reset = 1'b1;
      sample();
      check("midrst_ack", beat_ack, 4'b0000);
      advance();
      reset = 1'b0; req = 4'b0110;
      sample();
      check("midrst_grant", grant, 4'b0000);
      advance();
      sample();
      check("midrst_ptr0", grant, 4'b0010);
      advance();

      // Randomized traffic with sticky requests, random last/backpressure, rare resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         last      = 4'($urandom & $urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 199) == 0);
         a = 16'($urandom); b = 16'($urandom);
         c = 16'($urandom); d = 16'($urandom);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
